wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the physical-register writeback/commit ports between the issue-side functional units: MISC, ALU0, ALU1, MDU and MEM. Up to `NUM_PORT` results are granted per cycle by rotating-priority arbitration. Granted results are registered onto the writeback ports. Those ports feed the scheduler's wakeup inputs (`cmt_pdest_valid_i`/`cmt_pdest_i`) and the reorder buffer completion path.

## Interface

Parameters:
- `NUM_SRC`, 5, number of functional-unit requesters; index 0=MISC, 1=ALU0, 2=ALU1, 3=MDU, 4=MEM.
- `NUM_PORT`, 2, number of writeback ports; equals `COMMIT_WIDTH`; 1 ≤ `NUM_PORT` ≤ `NUM_SRC`.
- `PREG_W`, 6, physical register index width, `$clog2(PHY_REG_NUM)`.
- `ROB_W`, 6, ROB index width.
- `DATA_W`, 32, result width.

Ports:
- `clk`, input, 1, clock.
- `rst_n`, input, 1, reset; asynchronous, active-low.
- `flush_i`, input, 1, pipeline flush; synchronous.
- `src_valid_i`, input, `NUM_SRC`, result request per FU.
- `src_ready_o`, output, `NUM_SRC`, grant; transfer occurs when valid & ready.
- `src_pdest_valid_i`, input, `NUM_SRC`, result writes a physical register.
- `src_pdest_i`, input, `NUM_SRC`×`PREG_W`, destination physical register.
- `src_rob_idx_i`, input, `NUM_SRC`×`ROB_W`, ROB entry.
- `src_data_i`, input, `NUM_SRC`×`DATA_W`, result value.
- `wb_valid_o`, output, `NUM_PORT`, writeback port k carries a result.
- `wb_pdest_valid_o`, output, `NUM_PORT`, register write enable of port k.
- `wb_pdest_o`, output, `NUM_PORT`×`PREG_W`.
- `wb_rob_idx_o`, output, `NUM_PORT`×`ROB_W`.
- `wb_data_o`, output, `NUM_PORT`×`DATA_W`.
- `wb_src_o`, output, `NUM_PORT`×`$clog2(NUM_SRC)`, source FU index of port k.

## Operation

- **State:**
  - Rotating priority pointer `ptr`, width `$clog2(NUM_SRC)`, reset 0.
  - Output registers for all `wb_*` signals.
- **Grant (combinational):**
  - Scan sources in order `ptr`, `ptr+1`, … modulo `NUM_SRC`.
  - The first `NUM_PORT` sources with `src_valid_i` set are granted.
  - The k-th granted source in scan order is assigned port k.
- **Ready:**
  - `src_ready_o[i]` = granted[i] & ~`flush_i`.
  - Ready depends only on `src_valid_i` and `ptr`. It never depends on ready from another block.
- **Capture:**
  - Each cycle, port k registers the assigned source's fields and sets `wb_valid_o[k]`=1.
  - Ports with no assignment register `wb_valid_o[k]`=0 and `wb_pdest_valid_o[k]`=0.
  - Data fields of an unassigned port are don't-care but held stable; they are not cleared.
  - `wb_pdest_valid_o[k]` = `src_pdest_valid_i` of the assigned source, forced to 0 if `src_pdest_i`=0.
- **Pointer update:**
  - After a cycle with ≥1 grant and no flush: `ptr` ← (highest-order granted index in scan order + 1) mod `NUM_SRC`.
  - No grant: `ptr` holds.
  - Wrap from `NUM_SRC`-1 to 0 uses explicit compare; no power-of-two assumption.
- **Flush:**
  - `src_ready_o` = 0 in the flush cycle.
  - The next edge registers `wb_valid_o` = 0 and `wb_pdest_valid_o` = 0.
  - `ptr` holds.
  - Results already on the ports in the flush cycle remain visible that cycle; downstream discards them.
- **Fairness:** a source holding `src_valid_i` is granted within `ceil(NUM_SRC/NUM_PORT)` cycles (3 for the defaults).
- **Stability:** sources must hold valid and fields until granted; the arbiter does not check this.

## Timing

- Latency is 1 cycle: a grant at edge n puts the result on `wb_*` during cycle n+1.
- No bubbles: back-to-back grants to the same source are allowed each cycle.
- Throughput: `NUM_PORT` results per cycle.
- Reset values:
  - `wb_valid_o` = 0, `wb_pdest_valid_o` = 0.
  - `wb_pdest_o`, `wb_rob_idx_o`, `wb_data_o`, `wb_src_o` = 0.
  - `ptr` = 0.
  - `src_ready_o` = 0 while `rst_n` = 0.
- Reset is asynchronous at any point, including mid-stream; in-flight port contents are lost.
- When `flush_i` and `rst_n` deassertion coincide, the flush rule applies.

## Test plan

- **Single source:**
  - Stimulus: only ALU1 valid, pdest=0x12, rob=5, data=0xDEADBEEF.
  - Response: ready[2]=1 that cycle. Next cycle `wb_valid_o`=01 with port0 carrying those values and `wb_src_o`[0]=2. `ptr` becomes 3.
- **All five valid, held:**
  - Stimulus: all five sources hold valid from `ptr`=0.
  - Response: grants are {0,1}, then {2,3}, then {4,0}, then {1,2}. Every source is granted within 3 cycles.
- **Zero destination:**
  - Stimulus: MEM valid with `src_pdest_valid_i`=1 and pdest=0.
  - Response: `wb_valid_o`=1 and `wb_pdest_valid_o`=0 on its port.
- **Flush:**
  - Stimulus: sources 0 and 3 valid with `flush_i`=1.
  - Response: `src_ready_o`=0. Next cycle `wb_valid_o`=00. `ptr` is unchanged.
- **Wrap-around:**
  - Stimulus: `ptr`=4, sources 4 and 0 valid.
  - Response: port0 takes source 4 and port1 takes source 0. `ptr` becomes 1.
- **Reset mid-stream:**
  - Stimulus: assert `rst_n`=0 asynchronously while `wb_valid_o`=11.
  - Response: outputs clear immediately with no clock edge. After release, arbitration starts from `ptr`=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants up to NUM_PORT functional-unit results per
// cycle by rotating priority and registers them onto the writeback ports.
module wb_port_arbiter #(
    parameter int NUM_SRC  = 5,
    parameter int NUM_PORT = 2,
    parameter int PREG_W   = 6,
    parameter int ROB_W    = 6,
    parameter int DATA_W   = 32,
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic [NUM_SRC-1:0]           src_valid_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    input  logic [NUM_SRC-1:0]           src_pdest_valid_i,
    input  logic [NUM_SRC*PREG_W-1:0]    src_pdest_i,
    input  logic [NUM_SRC*ROB_W-1:0]     src_rob_idx_i,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data_i,
    output logic [NUM_PORT-1:0]          wb_valid_o,
    output logic [NUM_PORT-1:0]          wb_pdest_valid_o,
    output logic [NUM_PORT*PREG_W-1:0]   wb_pdest_o,
    output logic [NUM_PORT*ROB_W-1:0]    wb_rob_idx_o,
    output logic [NUM_PORT*DATA_W-1:0]   wb_data_o,
    output logic [NUM_PORT*SRC_W-1:0]    wb_src_o
);

    localparam int CNT_W = $clog2(NUM_PORT + 1);

    // Explicit compare so NUM_SRC need not be a power of two.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        if (v == SRC_W'(NUM_SRC - 1)) begin
            return {SRC_W{1'b0}};
        end else begin
            return v + SRC_W'(1);
        end
    endfunction

    logic [SRC_W-1:0]           ptr_q, ptr_d;
    logic [NUM_PORT-1:0]        wb_valid_q, wb_valid_d;
    logic [NUM_PORT-1:0]        wb_pdest_valid_q, wb_pdest_valid_d;
    logic [NUM_PORT*PREG_W-1:0] wb_pdest_q, wb_pdest_d;
    logic [NUM_PORT*ROB_W-1:0]  wb_rob_idx_q, wb_rob_idx_d;
    logic [NUM_PORT*DATA_W-1:0] wb_data_q, wb_data_d;
    logic [NUM_PORT*SRC_W-1:0]  wb_src_q, wb_src_d;

    logic [NUM_SRC-1:0]         grant_s;
    logic [NUM_PORT-1:0]        port_vld_s;
    logic [SRC_W-1:0]           port_sel_s [NUM_PORT];
    logic [SRC_W-1:0]           last_s;
    logic [SRC_W-1:0]           cur_s;
    logic [CNT_W-1:0]           cnt_s;
    logic                       take_s;
    logic                       cap_s;

    // Rotating scan from ptr: the k-th valid source found is assigned port k.
    always_comb begin
        grant_s    = {NUM_SRC{1'b0}};
        port_vld_s = {NUM_PORT{1'b0}};
        for (int k = 0; k < NUM_PORT; k++) begin
            port_sel_s[k] = {SRC_W{1'b0}};
        end
        last_s = ptr_q;
        cnt_s  = {CNT_W{1'b0}};
        cur_s  = ptr_q;
        take_s = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            take_s         = src_valid_i[cur_s] && (cnt_s < CNT_W'(NUM_PORT));
            grant_s[cur_s] = take_s;
            for (int k = 0; k < NUM_PORT; k++) begin
                port_vld_s[k] = port_vld_s[k] | (take_s && (cnt_s == CNT_W'(k)));
                port_sel_s[k] = (take_s && (cnt_s == CNT_W'(k))) ? cur_s : port_sel_s[k];
            end
            last_s = take_s ? cur_s : last_s;
            cnt_s  = cnt_s + CNT_W'(take_s);
            cur_s  = wrap_inc(cur_s);
        end
    end

    assign src_ready_o = grant_s & {NUM_SRC{~flush_i & rst_n}};

    // Next-state for pointer and writeback ports; unassigned ports hold their fields.
    always_comb begin
        ptr_d            = ptr_q;
        wb_valid_d       = {NUM_PORT{1'b0}};
        wb_pdest_valid_d = {NUM_PORT{1'b0}};
        wb_pdest_d       = wb_pdest_q;
        wb_rob_idx_d     = wb_rob_idx_q;
        wb_data_d        = wb_data_q;
        wb_src_d         = wb_src_q;
        cap_s            = 1'b0;
        if ((|grant_s) && !flush_i) begin
            ptr_d = wrap_inc(last_s);
        end else begin
            ptr_d = ptr_q;
        end
        for (int k = 0; k < NUM_PORT; k++) begin
            cap_s               = port_vld_s[k] & ~flush_i;
            wb_valid_d[k]       = cap_s;
            wb_pdest_valid_d[k] = cap_s & src_pdest_valid_i[port_sel_s[k]]
                & (src_pdest_i[port_sel_s[k]*PREG_W +: PREG_W] != {PREG_W{1'b0}});
            if (cap_s) begin
                wb_pdest_d[k*PREG_W +: PREG_W]  = src_pdest_i[port_sel_s[k]*PREG_W +: PREG_W];
                wb_rob_idx_d[k*ROB_W +: ROB_W]  = src_rob_idx_i[port_sel_s[k]*ROB_W +: ROB_W];
                wb_data_d[k*DATA_W +: DATA_W]   = src_data_i[port_sel_s[k]*DATA_W +: DATA_W];
                wb_src_d[k*SRC_W +: SRC_W]      = port_sel_s[k];
            end else begin
                wb_pdest_d[k*PREG_W +: PREG_W]  = wb_pdest_q[k*PREG_W +: PREG_W];
                wb_rob_idx_d[k*ROB_W +: ROB_W]  = wb_rob_idx_q[k*ROB_W +: ROB_W];
                wb_data_d[k*DATA_W +: DATA_W]   = wb_data_q[k*DATA_W +: DATA_W];
                wb_src_d[k*SRC_W +: SRC_W]      = wb_src_q[k*SRC_W +: SRC_W];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q            <= {SRC_W{1'b0}};
            wb_valid_q       <= {NUM_PORT{1'b0}};
            wb_pdest_valid_q <= {NUM_PORT{1'b0}};
            wb_pdest_q       <= {(NUM_PORT*PREG_W){1'b0}};
            wb_rob_idx_q     <= {(NUM_PORT*ROB_W){1'b0}};
            wb_data_q        <= {(NUM_PORT*DATA_W){1'b0}};
            wb_src_q         <= {(NUM_PORT*SRC_W){1'b0}};
        end else begin
            ptr_q            <= ptr_d;
            wb_valid_q       <= wb_valid_d;
            wb_pdest_valid_q <= wb_pdest_valid_d;
            wb_pdest_q       <= wb_pdest_d;
            wb_rob_idx_q     <= wb_rob_idx_d;
            wb_data_q        <= wb_data_d;
            wb_src_q         <= wb_src_d;
        end
    end

    assign wb_valid_o       = wb_valid_q;
    assign wb_pdest_valid_o = wb_pdest_valid_q;
    assign wb_pdest_o       = wb_pdest_q;
    assign wb_rob_idx_o     = wb_rob_idx_q;
    assign wb_data_o        = wb_data_q;
    assign wb_src_o         = wb_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed steps push expected port
// contents, a monitor pops and compares one cycle later.
module tb_wb_port_arbiter;

    localparam int NS = 5;
    localparam int NP = 2;
    localparam int PW = 6;
    localparam int RW = 6;
    localparam int DW = 32;
    localparam int SW = 3;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic [NS-1:0]     src_valid_i;
    logic [NS-1:0]     src_ready_o;
    logic [NS-1:0]     src_pdest_valid_i;
    logic [NS*PW-1:0]  src_pdest_i;
    logic [NS*RW-1:0]  src_rob_idx_i;
    logic [NS*DW-1:0]  src_data_i;
    logic [NP-1:0]     wb_valid_o;
    logic [NP-1:0]     wb_pdest_valid_o;
    logic [NP*PW-1:0]  wb_pdest_o;
    logic [NP*RW-1:0]  wb_rob_idx_o;
    logic [NP*DW-1:0]  wb_data_o;
    logic [NP*SW-1:0]  wb_src_o;

    wb_port_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush_i),
        .src_valid_i       (src_valid_i),
        .src_ready_o       (src_ready_o),
        .src_pdest_valid_i (src_pdest_valid_i),
        .src_pdest_i       (src_pdest_i),
        .src_rob_idx_i     (src_rob_idx_i),
        .src_data_i        (src_data_i),
        .wb_valid_o        (wb_valid_o),
        .wb_pdest_valid_o  (wb_pdest_valid_o),
        .wb_pdest_o        (wb_pdest_o),
        .wb_rob_idx_o      (wb_rob_idx_o),
        .wb_data_o         (wb_data_o),
        .wb_src_o          (wb_src_o)
    );

    typedef struct {
        string       name;
        logic [1:0]  v;
        logic [1:0]  pv;
        logic [2:0]  s0, s1;
        logic [5:0]  p0, p1;
        logic [5:0]  r0, r1;
        logic [31:0] d0, d1;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [PW-1:0] pd [NS];
    logic [RW-1:0] rb [NS];
    logic [DW-1:0] dt [NS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pack_fields();
        for (int i = 0; i < NS; i++) begin
            src_pdest_i[i*PW +: PW]   = pd[i];
            src_rob_idx_i[i*RW +: RW] = rb[i];
            src_data_i[i*DW +: DW]    = dt[i];
        end
    endtask

    task automatic step(input string nm, input logic [4:0] vld, input logic fl,
                        input logic zdst, input logic [4:0] exp_rdy,
                        input logic [1:0] exp_v, input logic [1:0] exp_pv,
                        input int s0, input int s1);
        exp_t e;
        @(negedge clk);
        pd[4] = zdst ? 6'h00 : 6'h34;
        pack_fields();
        src_valid_i = vld;
        flush_i     = fl;
        #1;
        chk({nm, " ready"}, 32'(src_ready_o), 32'(exp_rdy));
        e.name = nm;
        e.v  = exp_v;   e.pv = exp_pv;
        e.s0 = 3'(s0);  e.s1 = 3'(s1);
        e.p0 = pd[s0];  e.p1 = pd[s1];
        e.r0 = rb[s0];  e.r1 = rb[s1];
        e.d0 = dt[s0];  e.d1 = dt[s1];
        sb_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " wb_valid"},  32'(wb_valid_o), 32'h0);
        chk({nm, " wb_pvalid"}, 32'(wb_pdest_valid_o), 32'h0);
        chk({nm, " wb_pdest"},  32'(wb_pdest_o), 32'h0);
        chk({nm, " wb_rob"},    32'(wb_rob_idx_o), 32'h0);
        chk({nm, " wb_data0"},  wb_data_o[31:0], 32'h0);
        chk({nm, " wb_data1"},  wb_data_o[63:32], 32'h0);
        chk({nm, " wb_src"},    32'(wb_src_o), 32'h0);
        chk({nm, " ready"},     32'(src_ready_o), 32'h0);
    endtask

    // Monitor: compares the port contents registered at each edge that has an expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.name, " wb_valid"},  32'(wb_valid_o), 32'(e.v));
                chk({e.name, " wb_pvalid"}, 32'(wb_pdest_valid_o), 32'(e.pv));
                if (e.v[0]) begin
                    chk({e.name, " p0 src"},   32'(wb_src_o[2:0]), 32'(e.s0));
                    chk({e.name, " p0 pdest"}, 32'(wb_pdest_o[5:0]), 32'(e.p0));
                    chk({e.name, " p0 rob"},   32'(wb_rob_idx_o[5:0]), 32'(e.r0));
                    chk({e.name, " p0 data"},  wb_data_o[31:0], e.d0);
                end
                if (e.v[1]) begin
                    chk({e.name, " p1 src"},   32'(wb_src_o[5:3]), 32'(e.s1));
                    chk({e.name, " p1 pdest"}, 32'(wb_pdest_o[11:6]), 32'(e.p1));
                    chk({e.name, " p1 rob"},   32'(wb_rob_idx_o[11:6]), 32'(e.r1));
                    chk({e.name, " p1 data"},  wb_data_o[63:32], e.d1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pd[0] = 6'h01; pd[1] = 6'h0A; pd[2] = 6'h12; pd[3] = 6'h23; pd[4] = 6'h34;
        rb[0] = 6'd1;  rb[1] = 6'd2;  rb[2] = 6'd5;  rb[3] = 6'd7;  rb[4] = 6'd9;
        dt[0] = 32'h1111_0000; dt[1] = 32'h2222_0001; dt[2] = 32'hDEAD_BEEF;
        dt[3] = 32'h4444_0003; dt[4] = 32'h5555_0004;
        src_pdest_valid_i = 5'b11111;
        src_pdest_i   = '0;
        src_rob_idx_i = '0;
        src_data_i    = '0;
        pack_fields();
        flush_i     = 1'b0;
        src_valid_i = 5'b11111;
        rst_n       = 1'b0;
        #3;
        chk_reset_outputs("por");
        @(negedge clk);
        src_valid_i = 5'b00000;
        rst_n       = 1'b1;

        //    name          valid   fl    zd    ready     v      pv     s0 s1
        step("single",     5'b00100, 1'b0, 1'b0, 5'b00100, 2'b01, 2'b01, 2, 0);
        step("all_p3",     5'b11111, 1'b0, 1'b0, 5'b11000, 2'b11, 2'b11, 3, 4);
        step("all_a",      5'b11111, 1'b0, 1'b0, 5'b00011, 2'b11, 2'b11, 0, 1);
        step("all_b",      5'b11111, 1'b0, 1'b0, 5'b01100, 2'b11, 2'b11, 2, 3);
        step("all_c",      5'b11111, 1'b0, 1'b0, 5'b10001, 2'b11, 2'b11, 4, 0);
        step("all_d",      5'b11111, 1'b0, 1'b0, 5'b00110, 2'b11, 2'b11, 1, 2);
        step("flush",      5'b01001, 1'b1, 1'b0, 5'b00000, 2'b00, 2'b00, 0, 0);
        step("post_flush", 5'b11111, 1'b0, 1'b0, 5'b11000, 2'b11, 2'b11, 3, 4);
        step("zero_dst",   5'b10000, 1'b0, 1'b1, 5'b10000, 2'b01, 2'b00, 4, 0);
        step("to_p4",      5'b01000, 1'b0, 1'b0, 5'b01000, 2'b01, 2'b01, 3, 0);
        step("wrap",       5'b10001, 1'b0, 1'b0, 5'b10001, 2'b11, 2'b11, 4, 0);
        step("one_src0",   5'b00001, 1'b0, 1'b0, 5'b00001, 2'b01, 2'b01, 0, 0);
        step("idle",       5'b00000, 1'b0, 1'b0, 5'b00000, 2'b00, 2'b00, 0, 0);
        step("hold",       5'b00111, 1'b0, 1'b0, 5'b00110, 2'b11, 2'b11, 1, 2);
        step("pre_rst",    5'b01111, 1'b0, 1'b0, 5'b01001, 2'b11, 2'b11, 3, 0);

        // Ports now hold two results; reset lands mid-cycle, away from any edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        src_valid_i = 5'b00000;
        @(negedge clk);
        rst_n = 1'b1;

        step("post_rst",   5'b11111, 1'b0, 1'b0, 5'b00011, 2'b11, 2'b11, 0, 1);
        @(negedge clk);
        src_valid_i = 5'b00000;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("sb drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
